// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-Lite to APB4 bridge: bus encodings,
// the bridge state type and the write byte-strobe helper.
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } bridge_state_t;

   // Byte lanes covered by a transfer of 2**size bytes at the given low
   // address bits, aligned to the transfer size. Computed for an 8-lane bus;
   // narrower buses keep the low lanes and pass a zero in addr_lsbs[2].
   function automatic logic [7:0] calc_pstrb(input logic [2:0] size,
                                             input logic [2:0] addr_lsbs);
      logic [7:0] base;
      logic [2:0] offs;
      case (size)
         3'd0: begin
            base = 8'h01;
            offs = addr_lsbs;
         end
         3'd1: begin
            base = 8'h03;
            offs = {addr_lsbs[2:1], 1'b0};
         end
         3'd2: begin
            base = 8'h0F;
            offs = {addr_lsbs[2], 2'b00};
         end
         default: begin
            base = 8'hFF;
            offs = 3'd0;
         end
      endcase
      return base << offs;
   endfunction

endpackage

// File: rtl/apb_resp_mux.sv
// Combinational return-path selector: picks PRDATA/PREADY/PSLVERR of the
// addressed APB slave. Indices with no slave behind them return all zeros.
module apb_resp_mux #(
   parameter int NUM_SLAVES = 4,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = 2
) (
   input  logic [IDX_W-1:0]               sel_idx,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]          pready,
   input  logic [NUM_SLAVES-1:0]          pslverr,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic                           ready,
   output logic                           slverr
);

   logic [NUM_SLAVES-1:0] hit_s;

   // Decode the slave index into a one-hot hit vector.
   always_comb begin
      hit_s = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         hit_s[i] = (sel_idx == IDX_W'(i));
      end
   end

   // AND-OR merge of the hit slave's response; other slaves are masked out.
   always_comb begin
      rdata  = '0;
      ready  = 1'b0;
      slverr = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         rdata  = rdata  | ({DATA_WIDTH{hit_s[i]}} & prdata[i*DATA_WIDTH +: DATA_WIDTH]);
         ready  = ready  | (hit_s[i] & pready[i]);
         slverr = slverr | (hit_s[i] & pslverr[i]);
      end
   end

endmodule

// File: rtl/ahb_to_apb4_bridge.sv
// AHB-Lite slave to APB4 master bridge. One transfer in flight; reads go
// straight to SETUP, writes take one extra cycle to capture HWDATA. Slave
// index comes from HADDR[SLV_SEL_LSB +: idx_w]; unmapped indices and PSLVERR
// produce the two-cycle AHB ERROR response.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase watchdog that
// aborts with ERROR after TIMEOUT_CYCLES cycles of PREADY low.
module ahb_to_apb4_bridge
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int SLV_SEL_LSB    = 12,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           HCLK,
   input  logic                           HRESETn,
   input  logic                           HSEL,
   input  logic [ADDR_WIDTH-1:0]          HADDR,
   input  logic [1:0]                     HTRANS,
   input  logic                           HWRITE,
   input  logic [2:0]                     HSIZE,
   input  logic [3:0]                     HPROT,
   input  logic                           HREADY_IN,
   input  logic [DATA_WIDTH-1:0]          HWDATA,
   output logic [DATA_WIDTH-1:0]          HRDATA,
   output logic [1:0]                     HRESP,
   output logic                           HREADY_OUT,
   output logic [NUM_SLAVES-1:0]          PSEL,
   output logic                           PENABLE,
   output logic [ADDR_WIDTH-1:0]          PADDR,
   output logic                           PWRITE,
   output logic [DATA_WIDTH-1:0]          PWDATA,
   output logic [DATA_WIDTH/8-1:0]        PSTRB,
   output logic [2:0]                     PPROT,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]          PREADY,
   input  logic [NUM_SLAVES-1:0]          PSLVERR
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   // One extra bit so the slave count itself is representable.
   localparam logic [IDX_W:0]          SLV_LIMIT = (IDX_W + 1)'(NUM_SLAVES);
   localparam logic [NUM_SLAVES-1:0]   PSEL_BASE = NUM_SLAVES'(1);

   bridge_state_t           state_r;
   logic [IDX_W-1:0]        idx_r;
   logic [NUM_SLAVES-1:0]   psel_r;
   logic                    penable_r;
   logic [ADDR_WIDTH-1:0]   paddr_r;
   logic                    pwrite_r;
   logic [DATA_WIDTH-1:0]   pwdata_r;
   logic [STRB_W-1:0]       pstrb_r;
   logic [2:0]              pprot_r;

   logic                    active_s;
   logic                    accept_s;
   logic [IDX_W-1:0]        haddr_idx_s;
   logic                    unmapped_s;
   logic [2:0]              lsbs_s;
   logic [7:0]              strb_full_s;
   logic [STRB_W-1:0]       strb_s;
   logic                    hready_s;
   logic [1:0]              hresp_s;
   logic [DATA_WIDTH-1:0]   hrdata_s;
   logic                    complete_ok_s;
   logic [DATA_WIDTH-1:0]   sel_rdata_s;
   logic                    sel_ready_s;
   logic                    sel_err_s;
   logic                    tmo_hit_s;
   logic                    unused_prot_s;

   assign unused_prot_s = ^HPROT[3:2];

   apb_resp_mux #(
      .NUM_SLAVES (NUM_SLAVES),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_resp_mux (
      .sel_idx (idx_r),
      .prdata  (PRDATA),
      .pready  (PREADY),
      .pslverr (PSLVERR),
      .rdata   (sel_rdata_s),
      .ready   (sel_ready_s),
      .slverr  (sel_err_s)
   );

   // Only NONSEQ/SEQ request work; IDLE and BUSY get a zero-wait OKAY.
   always_comb begin
      case (HTRANS)
         HTRANS_NONSEQ, HTRANS_SEQ:  active_s = 1'b1;
         HTRANS_IDLE,   HTRANS_BUSY: active_s = 1'b0;
         default:                    active_s = 1'b0;
      endcase
   end

   // Address-phase decode: slave index, unmapped check, write strobes.
   always_comb begin
      haddr_idx_s = HADDR[SLV_SEL_LSB +: IDX_W];
      unmapped_s  = ({1'b0, haddr_idx_s} >= SLV_LIMIT);
      if (DATA_WIDTH == 64) begin
         lsbs_s = HADDR[2:0];
      end else begin
         lsbs_s = {1'b0, HADDR[1:0]};
      end
      strb_full_s = calc_pstrb(HSIZE, lsbs_s);
      strb_s      = strb_full_s[STRB_W-1:0];
   end

   // AHB data-phase response, driven from the state and the selected slave.
   always_comb begin
      hready_s      = 1'b1;
      hresp_s       = HRESP_OKAY;
      hrdata_s      = '0;
      complete_ok_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            hready_s = 1'b1;
         end
         ST_WDATA, ST_SETUP: begin
            hready_s = 1'b0;
         end
         ST_ACCESS: begin
            complete_ok_s = sel_ready_s & ~sel_err_s;
            hready_s      = complete_ok_s;
            if (complete_ok_s && !pwrite_r) begin
               hrdata_s = sel_rdata_s;
            end else begin
               hrdata_s = '0;
            end
         end
         ST_ERR1: begin
            hready_s = 1'b0;
            hresp_s  = HRESP_ERROR;
         end
         ST_ERR2: begin
            hready_s = 1'b1;
            hresp_s  = HRESP_ERROR;
         end
         default: begin
            hready_s = 1'b1;
         end
      endcase
   end

   // A new transfer is taken only while this bridge is itself ready.
   assign accept_s = HSEL & active_s & HREADY_IN & hready_s;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 9) ? $clog2(TIMEOUT_CYCLES + 1) : 9;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt_r;

   // A late PREADY wins over the timeout because sel_ready_s gates the hit.
   assign tmo_hit_s = (state_r == ST_ACCESS) & ~sel_ready_s & (tmo_cnt_r == CNT_LAST);

   // Count ACCESS cycles spent waiting; restart on every SETUP.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         tmo_cnt_r <= '0;
      end else if (state_r == ST_SETUP) begin
         tmo_cnt_r <= '0;
      end else if ((state_r == ST_ACCESS) && !sel_ready_s) begin
         tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end
`else
   logic unused_tmo_s;

   assign tmo_hit_s    = 1'b0;
   assign unused_tmo_s = TIMEOUT_CYCLES[0];
`endif

   // Bridge FSM together with all registered APB outputs.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r   <= ST_IDLE;
         idx_r     <= '0;
         psel_r    <= '0;
         penable_r <= 1'b0;
         paddr_r   <= '0;
         pwrite_r  <= 1'b0;
         pwdata_r  <= '0;
         pstrb_r   <= '0;
         pprot_r   <= 3'b000;
      end else if (accept_s) begin
         // Accept is only possible in IDLE, completing ACCESS or ERR2.
         paddr_r   <= HADDR;
         pwrite_r  <= HWRITE;
         pstrb_r   <= HWRITE ? strb_s : '0;
         pprot_r   <= {~HPROT[0], 1'b1, HPROT[1]};
         idx_r     <= haddr_idx_s;
         penable_r <= 1'b0;
         if (unmapped_s) begin
            state_r <= ST_ERR1;
            psel_r  <= '0;
         end else if (HWRITE) begin
            state_r <= ST_WDATA;
            psel_r  <= '0;
         end else begin
            state_r <= ST_SETUP;
            psel_r  <= PSEL_BASE << haddr_idx_s;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               psel_r    <= '0;
               penable_r <= 1'b0;
            end
            ST_WDATA: begin
               pwdata_r <= HWDATA;
               psel_r   <= PSEL_BASE << idx_r;
               state_r  <= ST_SETUP;
            end
            ST_SETUP: begin
               penable_r <= 1'b1;
               state_r   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (sel_ready_s) begin
                  psel_r    <= '0;
                  penable_r <= 1'b0;
                  state_r   <= sel_err_s ? ST_ERR1 : ST_IDLE;
               end else if (tmo_hit_s) begin
                  psel_r    <= '0;
                  penable_r <= 1'b0;
                  state_r   <= ST_ERR1;
               end else begin
                  state_r <= ST_ACCESS;
               end
            end
            ST_ERR1: begin
               psel_r    <= '0;
               penable_r <= 1'b0;
               state_r   <= ST_ERR2;
            end
            ST_ERR2: begin
               state_r <= ST_IDLE;
            end
            default: begin
               psel_r    <= '0;
               penable_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign HREADY_OUT = hready_s;
   assign HRESP      = hresp_s;
   assign HRDATA     = hrdata_s;
   assign PSEL       = psel_r;
   assign PENABLE    = penable_r;
   assign PADDR      = paddr_r;
   assign PWRITE     = pwrite_r;
   assign PWDATA     = pwdata_r;
   assign PSTRB      = pstrb_r;
   assign PPROT      = pprot_r;

endmodule

// File: tb/tb_ahb_to_apb4_bridge.sv
// Directed bench for ahb_to_apb4_bridge with three APB slaves, so slave
// index 3 is unmapped. Inputs change 1 time unit after the rising edge and
// outputs are checked 1 time unit later, well clear of the next edge.
module tb_ahb_to_apb4_bridge;
   import ahb_apb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 3;

   logic           HCLK;
   logic           HRESETn;
   logic           HSEL;
   logic [AW-1:0]  HADDR;
   logic [1:0]     HTRANS;
   logic           HWRITE;
   logic [2:0]     HSIZE;
   logic [3:0]     HPROT;
   logic           HREADY_IN;
   logic [DW-1:0]  HWDATA;
   logic [DW-1:0]  HRDATA;
   logic [1:0]     HRESP;
   logic           HREADY_OUT;
   logic [NS-1:0]  PSEL;
   logic           PENABLE;
   logic [AW-1:0]  PADDR;
   logic           PWRITE;
   logic [DW-1:0]  PWDATA;
   logic [DW/8-1:0] PSTRB;
   logic [2:0]     PPROT;
   logic [NS*DW-1:0] PRDATA;
   logic [NS-1:0]  PREADY;
   logic [NS-1:0]  PSLVERR;

   int errors = 0;
   int checks = 0;

   ahb_to_apb4_bridge #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .NUM_SLAVES     (NS),
      .SLV_SEL_LSB    (12),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .HSEL       (HSEL),
      .HADDR      (HADDR),
      .HTRANS     (HTRANS),
      .HWRITE     (HWRITE),
      .HSIZE      (HSIZE),
      .HPROT      (HPROT),
      .HREADY_IN  (HREADY_IN),
      .HWDATA     (HWDATA),
      .HRDATA     (HRDATA),
      .HRESP      (HRESP),
      .HREADY_OUT (HREADY_OUT),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PADDR      (PADDR),
      .PWRITE     (PWRITE),
      .PWDATA     (PWDATA),
      .PSTRB      (PSTRB),
      .PPROT      (PPROT),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR)
   );

   // 10-unit clock.
   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // Hard stop in case anything ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_idle();
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
   endtask

   task automatic drive_addr(input logic [AW-1:0] a, input logic w,
                             input logic [2:0] sz, input logic [3:0] prot);
      HSEL   = 1'b1;
      HTRANS = HTRANS_NONSEQ;
      HADDR  = a;
      HWRITE = w;
      HSIZE  = sz;
      HPROT  = prot;
   endtask

   task automatic chk_reset_values(input string pfx);
      chk({pfx, "_hready"}, 64'(HREADY_OUT), 64'h1);
      chk({pfx, "_hresp"},  64'(HRESP),      64'(HRESP_OKAY));
      chk({pfx, "_hrdata"}, 64'(HRDATA),     64'h0);
      chk({pfx, "_psel"},   64'(PSEL),       64'h0);
      chk({pfx, "_penable"},64'(PENABLE),    64'h0);
      chk({pfx, "_paddr"},  64'(PADDR),      64'h0);
      chk({pfx, "_pwrite"}, 64'(PWRITE),     64'h0);
      chk({pfx, "_pwdata"}, 64'(PWDATA),     64'h0);
      chk({pfx, "_pstrb"},  64'(PSTRB),      64'h0);
      chk({pfx, "_pprot"},  64'(PPROT),      64'h0);
   endtask

   // Zero-wait write to slave 0; checks strobes and data in SETUP.
   task automatic short_write(input string tag, input logic [AW-1:0] a,
                              input logic [2:0] sz, input logic [DW-1:0] d,
                              input logic [3:0] exp_strb);
      tick(); drive_addr(a, 1'b1, sz, 4'b0000); settle();
      tick(); drive_idle(); HWDATA = d; settle();
      chk({tag, "_wdata_hready"}, 64'(HREADY_OUT), 64'h0);
      tick(); HWDATA = 32'h0; settle();
      chk({tag, "_pstrb"},  64'(PSTRB),  64'(exp_strb));
      chk({tag, "_pwdata"}, 64'(PWDATA), 64'(d));
      chk({tag, "_psel"},   64'(PSEL),   64'h1);
      tick(); settle();
      chk({tag, "_done"},   64'(HREADY_OUT), 64'h1);
   endtask

   initial begin
      int  lat;
      int  acc;
      bit  done;

      HRESETn   = 1'b0;
      drive_idle();
      HADDR     = '0;
      HWRITE    = 1'b0;
      HSIZE     = 3'd0;
      HPROT     = 4'b0000;
      HREADY_IN = 1'b1;
      HWDATA    = '0;
      PRDATA    = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0BAD_0000};
      PREADY    = 3'b111;
      PSLVERR   = 3'b000;

      // Reset state
      tick(); tick(); settle();
      chk_reset_values("rst");
      HRESETn = 1'b1;

      // Read from slave 1, zero wait
      tick(); drive_addr(32'h0000_1000, 1'b0, 3'd2, 4'b0001); settle();
      chk("rd_idle_hready", 64'(HREADY_OUT), 64'h1);
      tick(); drive_idle(); settle();
      chk("rd_setup_psel",    64'(PSEL),       64'h2);
      chk("rd_setup_penable", 64'(PENABLE),    64'h0);
      chk("rd_setup_hready",  64'(HREADY_OUT), 64'h0);
      chk("rd_setup_paddr",   64'(PADDR),      64'h1000);
      chk("rd_setup_pprot",   64'(PPROT),      64'h2);
      chk("rd_setup_pstrb",   64'(PSTRB),      64'h0);
      chk("rd_setup_hrdata",  64'(HRDATA),     64'h0);
      tick(); settle();
      chk("rd_access_psel",    64'(PSEL),       64'h2);
      chk("rd_access_penable", 64'(PENABLE),    64'h1);
      chk("rd_access_hready",  64'(HREADY_OUT), 64'h1);
      chk("rd_access_hrdata",  64'(HRDATA),     64'hDEAD_BEEF);
      chk("rd_access_hresp",   64'(HRESP),      64'(HRESP_OKAY));
      tick(); settle();
      chk("rd_after_psel",   64'(PSEL),       64'h0);
      chk("rd_after_hrdata", 64'(HRDATA),     64'h0);
      chk("rd_after_hready", 64'(HREADY_OUT), 64'h1);

      // Word write to slave 0 with three PREADY-low ACCESS cycles
      tick(); drive_addr(32'h0000_0004, 1'b1, 3'd2, 4'b0011); settle();
      tick(); drive_idle(); HWDATA = 32'h1234_5678; PREADY[0] = 1'b0; settle();
      chk("wr_wdata_hready", 64'(HREADY_OUT), 64'h0);
      chk("wr_wdata_psel",   64'(PSEL),       64'h0);
      lat  = 1;
      acc  = 0;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         tick();
         HWDATA = 32'hFFFF_FFFF;
         if (PENABLE) begin
            acc++;
            PREADY[0] = (acc > 3);
         end
         settle();
         lat++;
         if (lat == 2) begin
            chk("wr_setup_psel",    64'(PSEL),    64'h1);
            chk("wr_setup_penable", 64'(PENABLE), 64'h0);
            chk("wr_setup_pwdata",  64'(PWDATA),  64'h1234_5678);
            chk("wr_setup_pstrb",   64'(PSTRB),   64'hF);
            chk("wr_setup_pwrite",  64'(PWRITE),  64'h1);
            chk("wr_setup_pprot",   64'(PPROT),   64'h3);
            chk("wr_setup_paddr",   64'(PADDR),   64'h4);
         end else if (lat < 6) begin
            chk("wr_wait_hready", 64'(HREADY_OUT), 64'h0);
         end
         if (HREADY_OUT) begin
            done = 1'b1;
            chk("wr_done_hrdata", 64'(HRDATA), 64'h0);
            chk("wr_done_hresp",  64'(HRESP),  64'(HRESP_OKAY));
            chk("wr_done_pwdata", 64'(PWDATA), 64'h1234_5678);
         end
      end
      chk("wr_completed", 64'(done), 64'h1);
      chk("wr_latency",   64'(lat),  64'd6);
      PREADY = 3'b111;

      // Sub-word writes
      short_write("hw", 32'h0000_0002, 3'd1, 32'hABCD_0000, 4'b1100);
      short_write("by", 32'h0000_0003, 3'd0, 32'h5500_0000, 4'b1000);

      // PSLVERR from slave 2
      tick(); PSLVERR = 3'b100; drive_addr(32'h0000_2000, 1'b0, 3'd2, 4'b0000); settle();
      tick(); drive_idle(); settle();
      chk("slverr_setup_psel", 64'(PSEL), 64'h4);
      tick(); settle();
      chk("slverr_access_hready", 64'(HREADY_OUT), 64'h0);
      chk("slverr_access_hresp",  64'(HRESP),      64'(HRESP_OKAY));
      chk("slverr_access_hrdata", 64'(HRDATA),     64'h0);
      tick(); settle();
      chk("slverr_err1_hresp",  64'(HRESP),      64'(HRESP_ERROR));
      chk("slverr_err1_hready", 64'(HREADY_OUT), 64'h0);
      chk("slverr_err1_psel",   64'(PSEL),       64'h0);
      tick(); settle();
      chk("slverr_err2_hresp",  64'(HRESP),      64'(HRESP_ERROR));
      chk("slverr_err2_hready", 64'(HREADY_OUT), 64'h1);
      tick(); PSLVERR = 3'b000; settle();
      chk("slverr_after_hresp",  64'(HRESP),      64'(HRESP_OKAY));
      chk("slverr_after_hready", 64'(HREADY_OUT), 64'h1);

      // Unmapped slave index 3
      tick(); drive_addr(32'h0000_3000, 1'b0, 3'd2, 4'b0000); settle();
      tick(); drive_idle(); settle();
      chk("unmap_err1_hresp",  64'(HRESP),      64'(HRESP_ERROR));
      chk("unmap_err1_hready", 64'(HREADY_OUT), 64'h0);
      chk("unmap_err1_psel",   64'(PSEL),       64'h0);
      tick(); settle();
      chk("unmap_err2_hresp",  64'(HRESP),      64'(HRESP_ERROR));
      chk("unmap_err2_hready", 64'(HREADY_OUT), 64'h1);
      chk("unmap_err2_psel",   64'(PSEL),       64'h0);
      tick(); settle();
      chk("unmap_after_hresp", 64'(HRESP), 64'(HRESP_OKAY));

      // Back-to-back: read s1, read s2, write s0
      tick(); drive_addr(32'h0000_1004, 1'b0, 3'd2, 4'b0000); settle();
      tick(); drive_addr(32'h0000_2008, 1'b0, 3'd2, 4'b0000); settle();
      chk("b2b_setup1_paddr",  64'(PADDR),      64'h1004);
      chk("b2b_setup1_hready", 64'(HREADY_OUT), 64'h0);
      tick(); settle();
      chk("b2b_access1_hrdata", 64'(HRDATA),     64'hDEAD_BEEF);
      chk("b2b_access1_hready", 64'(HREADY_OUT), 64'h1);
      tick(); drive_addr(32'h0000_0010, 1'b1, 3'd2, 4'b0000); settle();
      chk("b2b_setup2_psel",    64'(PSEL),    64'h4);
      chk("b2b_setup2_penable", 64'(PENABLE), 64'h0);
      chk("b2b_setup2_paddr",   64'(PADDR),   64'h2008);
      tick(); settle();
      chk("b2b_access2_hrdata", 64'(HRDATA),     64'hCAFE_F00D);
      chk("b2b_access2_hready", 64'(HREADY_OUT), 64'h1);
      tick(); drive_idle(); HWDATA = 32'h5A5A_5A5A; settle();
      chk("b2b_wdata_psel",   64'(PSEL),       64'h0);
      chk("b2b_wdata_hready", 64'(HREADY_OUT), 64'h0);
      tick(); settle();
      chk("b2b_setup3_psel",   64'(PSEL),   64'h1);
      chk("b2b_setup3_pwdata", 64'(PWDATA), 64'h5A5A_5A5A);
      chk("b2b_setup3_paddr",  64'(PADDR),  64'h10);
      chk("b2b_setup3_pwrite", 64'(PWRITE), 64'h1);
      tick(); settle();
      chk("b2b_access3_hready", 64'(HREADY_OUT), 64'h1);

      // Transfers that must be ignored: HSEL low, HREADY_IN low, BUSY
      tick(); drive_addr(32'h0000_1000, 1'b0, 3'd2, 4'b0000); HSEL = 1'b0; settle();
      tick(); drive_addr(32'h0000_1000, 1'b0, 3'd2, 4'b0000); HREADY_IN = 1'b0; settle();
      chk("nosel_psel",   64'(PSEL),       64'h0);
      chk("nosel_hready", 64'(HREADY_OUT), 64'h1);
      tick(); HREADY_IN = 1'b1; HTRANS = HTRANS_BUSY; settle();
      chk("nordy_psel", 64'(PSEL), 64'h0);
      tick(); drive_idle(); settle();
      chk("busy_psel",   64'(PSEL),       64'h0);
      chk("busy_hready", 64'(HREADY_OUT), 64'h1);
      chk("busy_hresp",  64'(HRESP),      64'(HRESP_OKAY));

`ifdef APB_TIMEOUT_EN
      // Timeout after 4 ACCESS cycles with PREADY stuck low
      tick(); PREADY = 3'b110; drive_addr(32'h0000_0000, 1'b0, 3'd2, 4'b0000); settle();
      tick(); drive_idle(); settle();
      acc  = 0;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         tick(); settle();
         if (PENABLE) begin
            acc++;
         end else begin
            done = 1'b1;
         end
      end
      chk("tmo_access_cycles", 64'(acc),        64'd4);
      chk("tmo_err1_hresp",    64'(HRESP),      64'(HRESP_ERROR));
      chk("tmo_err1_hready",   64'(HREADY_OUT), 64'h0);
      chk("tmo_err1_psel",     64'(PSEL),       64'h0);
      tick(); settle();
      chk("tmo_err2_hresp",  64'(HRESP),      64'(HRESP_ERROR));
      chk("tmo_err2_hready", 64'(HREADY_OUT), 64'h1);
      tick(); PREADY = 3'b111; settle();
`endif

      // Async reset in the middle of a write ACCESS
      tick(); PREADY = 3'b110; drive_addr(32'h0000_0008, 1'b1, 3'd2, 4'b0000); settle();
      tick(); drive_idle(); HWDATA = 32'h0000_0077; settle();
      tick(); settle();
      tick(); settle();
      chk("arst_pre_penable", 64'(PENABLE), 64'h1);
      chk("arst_pre_paddr",   64'(PADDR),   64'h8);
      #2;
      HRESETn = 1'b0;
      #1;
      chk_reset_values("arst");
      #2;
      HRESETn = 1'b1;
      PREADY  = 3'b111;
      tick(); settle();
      chk("arst_after_psel",    64'(PSEL),       64'h0);
      chk("arst_after_penable", 64'(PENABLE),    64'h0);
      chk("arst_after_hready",  64'(HREADY_OUT), 64'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
